// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache
//
// Direct-mapped instruction cache, one 32-bit word per line, read-only from
// the core's side. A hit is served combinationally for the current fetch
// address. A miss starts a single outstanding refill to the memory
// controller; the returned word is written into the line and the lookup
// hits on the following cycle.
//
// Ports:
//   clk             clock, rising edge
//   rst             synchronous active-high reset (wins over rdy)
//   rdy             global ready; low freezes all state
//   fetch_addr      fetch PC, bits [1:0] ignored
//   instr_valid     fetch_addr hits this cycle (combinational)
//   instr           cached word for fetch_addr
//   mem_req_valid   refill request, held until the response arrives
//   mem_req_addr    word-aligned refill address
//   mem_resp_valid  refill response pulse
//   mem_resp_data   refill data
// ---------------------------------------------------------------------------
module icache #(
    parameter int INDEX_BITS = 8,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] fetch_addr,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int DEPTH = 1 << INDEX_BITS;

    typedef enum logic {
        ST_IDLE,
        ST_REFILL
    } state_t;

    state_t                r_state;
    logic [DEPTH-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag  [DEPTH];
    logic [31:0]           r_data [DEPTH];
    logic [31:0]           r_miss_addr;
    logic                  r_req_valid;

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic [INDEX_BITS-1:0] w_fill_index;
    logic [TAG_BITS-1:0]   w_fill_tag;
    logic                  w_hit;
    logic                  w_fill;
    logic                  w_unused_addr;

    assign w_index       = fetch_addr[INDEX_BITS+1:2];
    assign w_tag         = fetch_addr[31:INDEX_BITS+2];
    assign w_unused_addr = ^fetch_addr[1:0];

    // The fill always targets the latched miss address, never the live
    // fetch address, so a redirect during refill still fills the old line.
    assign w_fill_index  = r_miss_addr[INDEX_BITS+1:2];
    assign w_fill_tag    = r_miss_addr[31:INDEX_BITS+2];

    assign w_hit         = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign instr_valid   = (r_state == ST_IDLE) && w_hit;
    assign instr         = r_data[w_index];

    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = r_miss_addr;

    // A response is consumed only in REFILL with rdy high; reset blocks it.
    assign w_fill = (r_state == ST_REFILL) && mem_resp_valid && rdy && !rst;

    // Tag/data storage carries no reset; line validity lives in r_valid.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= mem_resp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_valid     <= '0;
            r_req_valid <= 1'b0;
            r_miss_addr <= '0;
        end else if (rdy) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_hit) begin
                        r_miss_addr <= {fetch_addr[31:2], 2'b00};
                        r_req_valid <= 1'b1;
                        r_state     <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (mem_resp_valid) begin
                        r_valid[w_fill_index] <= 1'b1;
                        r_req_valid           <= 1'b0;
                        r_state               <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// ---------------------------------------------------------------------------
// tb_icache
//
// Directed plus randomized bench for icache. The reference model keeps, per
// cache index, the word address currently held there, and a memory image
// computed from a hash of the address (with a few fixed overrides).
// ---------------------------------------------------------------------------
module tb_icache;

    localparam int IB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] fetch_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_ovr [logic [31:0]];
    logic [31:0] cached  [int];
    logic [31:0] seed_word;

    always #5 clk = ~clk;

    icache #(.INDEX_BITS(IB)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .fetch_addr     (fetch_addr),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    function automatic logic [31:0] waddr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) & ((32'd1 << IB) - 1));
    endfunction

    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [31:0] w;
        w = waddr(a);
        if (mem_ovr.exists(w)) return mem_ovr[w];
        return (w * 32'h9E37_79B1) ^ seed_word ^ {w[15:0], w[31:16]};
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int i;
        i = idx_of(a);
        return cached.exists(i) && (cached[i] == waddr(a));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access: hit in one cycle, or miss + refill with the
    // response arriving k cycles after the request goes up.
    task automatic fetch(input logic [31:0] a, input int k);
        fetch_addr     = a;
        rdy            = 1'b1;
        mem_resp_valid = 1'b0;
        #1;
        if (model_hit(a)) begin
            chk("hit_valid", {31'd0, instr_valid}, 32'd1);
            chk("hit_data", instr, memword(a));
            chk("hit_noreq", {31'd0, mem_req_valid}, 32'd0);
            $display("access %h hit data=%h", a, instr);
            tick();
        end else begin
            chk("miss_valid", {31'd0, instr_valid}, 32'd0);
            tick();
            for (int j = 1; j <= k; j++) begin
                #1;
                chk("req_valid", {31'd0, mem_req_valid}, 32'd1);
                chk("req_addr", mem_req_addr, waddr(a));
                chk("refill_novalid", {31'd0, instr_valid}, 32'd0);
                if (j == k) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = memword(a);
                end
                tick();
            end
            mem_resp_valid = 1'b0;
            cached[idx_of(a)] = waddr(a);
            #1;
            chk("req_cleared", {31'd0, mem_req_valid}, 32'd0);
            chk("fill_valid", {31'd0, instr_valid}, 32'd1);
            chk("fill_data", instr, memword(a));
            $display("access %h miss k=%0d data=%h", a, k, instr);
            tick();
        end
    endtask

    initial begin
        logic [31:0] a;
        seed_word      = $urandom;
        mem_ovr[32'h0] = 32'h0000_0093;
        rst            = 1'b1;
        rdy            = 1'b1;
        fetch_addr     = 32'h0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;

        // Reset state
        tick(); tick(); tick();
        #1;
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_addr", mem_req_addr, 32'h0);
        $display("reset state req=%b addr=%h", mem_req_valid, mem_req_addr);
        rst = 1'b0;
        tick();

        // Cold miss, response 3 cycles after request
        fetch(32'h0, 3);

        // Hit stream
        fetch(32'h4, 1);
        fetch(32'h8, 1);
        fetch(32'hC, 1);
        fetch(32'h0, 1);
        fetch(32'h4, 1);
        fetch(32'h8, 1);
        fetch(32'hC, 1);

        // Conflict eviction
        fetch(32'h10, 1);
        fetch(32'h410, 2);
        fetch(32'h10, 1);

        // Stray response in IDLE while hitting must not write any line
        fetch_addr     = 32'h10;
        mem_resp_valid = 1'b1;
        mem_resp_data  = ~memword(32'h10);
        #1;
        chk("stray_idle_hit", {31'd0, instr_valid}, 32'd1);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("stray_idle_data", instr, memword(32'h10));
        chk("stray_idle_noreq", {31'd0, mem_req_valid}, 32'd0);
        $display("stray response in idle data=%h", instr);
        tick();

        // Redirect mid-refill
        fetch_addr = 32'h100;
        tick();
        #1;
        chk("redir_req_addr", mem_req_addr, 32'h100);
        fetch_addr = 32'h200;
        #1;
        chk("redir_novalid", {31'd0, instr_valid}, 32'd0);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = memword(32'h100);
        tick();
        mem_resp_valid = 1'b0;
        cached[idx_of(32'h100)] = 32'h100;
        #1;
        chk("redir_req_drop", {31'd0, mem_req_valid}, 32'd0);
        chk("redir_new_miss", {31'd0, instr_valid}, 32'd0);
        $display("redirect 0x100->0x200 req=%b", mem_req_valid);
        fetch(32'h200, 2);
        fetch(32'h100, 1);

        // Reset mid-refill, coincident and stray responses
        fetch_addr = 32'h300;
        tick();
        #1;
        chk("rstmid_req", {31'd0, mem_req_valid}, 32'd1);
        rst            = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        tick();
        rst        = 1'b0;
        rdy        = 1'b0;
        fetch_addr = 32'h0;
        cached.delete();
        #1;
        chk("rstmid_req_low", {31'd0, mem_req_valid}, 32'd0);
        chk("rstmid_addr", mem_req_addr, 32'h0);
        chk("rstmid_invalid", {31'd0, instr_valid}, 32'd0);
        $display("reset during refill req=%b", mem_req_valid);
        tick();
        rdy        = 1'b1;
        fetch_addr = 32'h300;
        #1;
        chk("rstmid_remiss", {31'd0, instr_valid}, 32'd0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("rstmid_newreq", {31'd0, mem_req_valid}, 32'd1);
        chk("rstmid_newaddr", mem_req_addr, 32'h300);
        mem_resp_valid = 1'b1;
        mem_resp_data  = memword(32'h300);
        tick();
        mem_resp_valid = 1'b0;
        cached[idx_of(32'h300)] = 32'h300;
        #1;
        chk("rstmid_fill", instr, memword(32'h300));
        chk("rstmid_fill_valid", {31'd0, instr_valid}, 32'd1);
        tick();
        fetch(32'h0, 1);

        // rdy freeze in IDLE: no request may start
        rdy        = 1'b0;
        fetch_addr = 32'h500;
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            chk("freeze_idle_noreq", {31'd0, mem_req_valid}, 32'd0);
        end
        rdy = 1'b1;
        tick();
        // rdy freeze in REFILL with a held response
        rdy            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = memword(32'h500);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("freeze_req", {31'd0, mem_req_valid}, 32'd1);
            chk("freeze_addr", mem_req_addr, 32'h500);
            chk("freeze_novalid", {31'd0, instr_valid}, 32'd0);
            tick();
        end
        rdy = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        cached[idx_of(32'h500)] = 32'h500;
        #1;
        chk("freeze_done_req", {31'd0, mem_req_valid}, 32'd0);
        chk("freeze_done_data", instr, memword(32'h500));
        chk("freeze_done_valid", {31'd0, instr_valid}, 32'd1);
        $display("rdy freeze refill done data=%h", instr);
        tick();

        // Top address and ignored low bits
        fetch(32'hFFFF_FFFC, 1);
        fetch(32'hFFFF_FFFF, 1);

        // Randomized accesses over a small aliasing pool
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom;
            end else begin
                a = (32'($urandom_range(0, 3)) << 10) |
                    (32'($urandom_range(0, 15)) << 2) |
                    32'($urandom_range(0, 3));
            end
            fetch(a, int'($urandom_range(1, 4)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
